sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the adder sum width consumed per term.
REQ-002 The block SHALL have parameter GUARD, default 8, giving the accumulator guard bits above WIDTH.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the term-count width.
REQ-004 Port clk SHALL be input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 Port rst_n SHALL be input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port start SHALL be input, 1 bit: begins a new accumulation run.
REQ-007 Port num_terms SHALL be input, CNT_W bits: the number of terms in the run, sampled with start.
REQ-008 Port in_valid SHALL be input, 1 bit: in_sum and in_cout carry a term.
REQ-009 Port in_ready SHALL be output, 1 bit: the block accepts a term this cycle.
REQ-010 Port in_sum SHALL be input, WIDTH bits: the registered sum from the upstream 64-bit adder.
REQ-011 Port in_cout SHALL be input, 1 bit: the registered carry-out from the upstream adder; it forms bit WIDTH of the term.
REQ-012 Port out_valid SHALL be output, 1 bit: the result is available.
REQ-013 Port out_ready SHALL be input, 1 bit: the consumer takes the result.
REQ-014 Port out_acc SHALL be output, WIDTH+GUARD bits: the accumulated result.
REQ-015 Port out_ovf SHALL be output, 1 bit: a sticky flag indicating that a carry was lost beyond bit WIDTH+GUARD-1.
REQ-016 Port busy SHALL be output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-018 In IDLE, start=1 with num_terms>0 SHALL load the remaining-count register with num_terms, clear the accumulator and ovf, and enter ACCUM.
REQ-019 In IDLE, start=1 with num_terms=0 SHALL clear the accumulator and ovf and enter HOLD, so out_valid=1 on the next cycle with out_acc=0.
REQ-020 start SHALL be ignored in ACCUM and HOLD.
REQ-021 in_ready SHALL be 1 only in ACCUM; it is registered or purely state-decoded, with no combinational path from in_valid.
REQ-022 A term SHALL be accepted on an edge where in_valid=1 and in_ready=1.
REQ-023 On acceptance, acc SHALL be updated to acc + zero_extend({in_cout, in_sum}) modulo 2^(WIDTH+GUARD).
REQ-024 On acceptance, ovf SHALL be set if that addition carries out of bit WIDTH+GUARD-1; ovf never clears within a run.
REQ-025 On acceptance, the remaining count SHALL decrement by 1.
REQ-026 Cycles in ACCUM with in_valid=0 SHALL change neither acc, ovf nor the remaining count.
REQ-027 Acceptance while the remaining count equals 1 SHALL transition the FSM to HOLD.
REQ-028 out_valid SHALL rise on the edge following the final acceptance, giving 1-cycle latency.
REQ-029 Throughput SHALL be one term per cycle.
REQ-030 In HOLD, out_valid SHALL be 1 and out_acc and out_ovf SHALL be stable.
REQ-031 In HOLD, out_ready=1 SHALL return the FSM to IDLE on that edge, with out_valid=0 on the next cycle.
REQ-032 out_acc and out_ovf SHALL retain their last values in IDLE until the next start.
REQ-033 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-034 The in-side and out-side handshakes SHALL never be simultaneously active, because in_ready=0 in HOLD.

Reset
REQ-035 On rst_n=0, the block SHALL immediately, and asynchronously, enter IDLE.
REQ-036 On rst_n=0, acc, out_acc, out_ovf, the remaining count, in_ready, out_valid and busy SHALL be set to 0.
REQ-037 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the run; no partial result is presented.
REQ-038 After rst_n deasserts, the block SHALL take no action until the next start.

Verification
REQ-039 The bench SHALL cover a basic 3-term run: num_terms=3 with terms {cout,sum} = {0,5}, {0,7}, {1,0}, accepted back-to-back -> out_valid=1 exactly one cycle after the third acceptance, out_acc = 0x00_1_0000000000000000 + 0xC (=2^64+12), out_ovf=0.
REQ-040 The bench SHALL cover a zero-term run: start with num_terms=0 -> out_valid=1 on the next cycle, out_acc=0, out_ovf=0, in_ready never asserted.
REQ-041 The bench SHALL cover overflow: num_terms=255 with every term {1, all-ones} -> out_ovf=1, out_acc = (255*(2^65-1)) mod 2^72.
REQ-042 The bench SHALL cover input bubbles: num_terms=4 with in_valid toggling 1,0,0,1,1,0,1 and terms 1,2,3,4 -> out_acc=10, out_valid one cycle after the 7th stimulus cycle.
REQ-043 The bench SHALL cover output back-pressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_acc and out_ovf held, in_ready=0, start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-044 The bench SHALL cover reset mid-run: rst_n pulled low after 2 of 4 terms -> all outputs 0 immediately; a new run with num_terms=1 and term 9 -> out_acc=9, with no carry-over from the aborted run.

Source files
------------

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - multi-term accumulator behind a registered adder, with sticky guard overflow
module sum_accumulator #(
  parameter int WIDTH = 64,
  parameter int GUARD = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_terms,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_sum,
  input  logic                   in_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+GUARD-1:0] out_acc,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int AW = WIDTH + GUARD;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q;
  logic [AW-1:0]    acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [AW:0]      sum_ext;
  logic [AW-1:0]    acc_d;
  logic             carry_d;

  // The carry-out of the upstream adder is bit WIDTH of the term.
  assign sum_ext = {1'b0, acc_q} + {{(AW-WIDTH){1'b0}}, in_cout, in_sum};
  assign acc_d   = sum_ext[AW-1:0];
  assign carry_d = sum_ext[AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (num_terms != '0) begin
              cnt_q      <= num_terms;
              in_ready_q <= 1'b1;
              state_q    <= ACCUM;
            end else begin
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | carry_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - randomized self-checking bench for sum_accumulator against an arithmetic model
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_terms = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_sum = '0;
  logic        in_cout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_acc;
  logic        out_ovf;
  logic        busy;

  int total = 0;
  int bad = 0;

  // Reference: exact running total of every accepted term in wide arithmetic.
  logic [127:0] exp_total;

  sum_accumulator #(.WIDTH(64), .GUARD(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got still running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_acc();
    return {56'd0, exp_total[71:0]};
  endfunction

  function automatic logic exp_ovf();
    return |exp_total[127:72];
  endfunction

  task automatic start_run(input logic [7:0] n);
    start = 1'b1;
    num_terms = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    num_terms = $urandom;
    exp_total = '0;
    check("start_busy", busy, 1);
    check("start_rdy", in_ready, n != 0);
    check("start_ov", out_valid, n == 0);
  endtask

  task automatic accept_term(input logic [64:0] term);
    in_valid = 1'b1;
    {in_cout, in_sum} = term;
    @(negedge clk);
    check("acc_rdy", in_ready, 1);
    check("acc_ov", out_valid, 0);
    @(posedge clk);
    exp_total = exp_total + {63'd0, term};
    #1;
    in_valid = 1'b0;
    {in_cout, in_sum} = {1'b0, $urandom, $urandom};
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    {in_cout, in_sum} = {1'b1, $urandom, $urandom};
    @(negedge clk);
    check("bub_busy", busy, 1);
    check("bub_acc", out_acc, exp_acc());
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run(input int hold);
    check("fin_ov", out_valid, 1);
    check("fin_rdy", in_ready, 0);
    check("fin_acc", out_acc, exp_acc());
    check("fin_ovf", out_ovf, exp_ovf());
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      start = 1'b1;
      num_terms = $urandom;
      in_valid = $urandom;
      @(posedge clk);
      #1;
      start = 1'b0;
      in_valid = 1'b0;
      check("hold_ov", out_valid, 1);
      check("hold_rdy", in_ready, 0);
      check("hold_acc", out_acc, exp_acc());
      check("hold_ovf", out_ovf, exp_ovf());
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("rel_ov", out_valid, 0);
    check("rel_busy", busy, 0);
    @(posedge clk);
    #1;
    check("idle_acc", out_acc, exp_acc());
    check("idle_ovf", out_ovf, exp_ovf());
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [64:0] t3 [3];
    bit          pat [7];
    logic [127:0] ovf_ref;
    int n;
    exp_total = '0;

    #3;
    check("rst_acc", out_acc, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_ov", out_valid, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);

    // Three back-to-back terms, the last one carried in on in_cout.
    t3[0] = {1'b0, 64'd5};
    t3[1] = {1'b0, 64'd7};
    t3[2] = {1'b1, 64'd0};
    start_run(8'd3);
    for (int i = 0; i < 3; i++) accept_term(t3[i]);
    check("t3_const", out_acc, 128'h01_0000_0000_0000_000C);
    finish_run(0);

    start_run(8'd0);
    check("zero_acc", out_acc, 0);
    check("zero_ovf", out_ovf, 0);
    finish_run(1);

    start_run(8'd255);
    for (int i = 0; i < 255; i++) accept_term({1'b1, {64{1'b1}}});
    ovf_ref = 128'd255 * ((128'd1 << 65) - 128'd1);
    check("ovf_const_acc", out_acc, {56'd0, ovf_ref[71:0]});
    check("ovf_const_flag", out_ovf, 1);
    finish_run(0);

    pat = '{1, 0, 0, 1, 1, 0, 1};
    n = 1;
    start_run(8'd4);
    for (int c = 0; c < 7; c++) begin
      if (pat[c]) begin
        accept_term({1'b0, 64'(n)});
        n++;
      end else begin
        idle_cycle();
      end
    end
    check("bub_const", out_acc, 10);
    finish_run(5);

    // Abort after two of four terms; reset must act without a clock edge.
    start_run(8'd4);
    accept_term({1'b1, 64'hFFFF_0000_1234_5678});
    accept_term({1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_acc", out_acc, 0);
    check("mid_rst_ovf", out_ovf, 0);
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("post_abort_busy", busy, 0);
      check("post_abort_acc", out_acc, 0);
    end
    in_valid = 1'b0;
    start_run(8'd1);
    accept_term({1'b0, 64'd9});
    check("nine_const", out_acc, 9);
    finish_run(2);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20);
      start_run(8'(n));
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 2) == 0) idle_cycle();
        accept_term({1'($urandom), $urandom, $urandom});
      end
      finish_run($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
